// File: rtl/packet_check_if.sv
// Receive-side beat stream from the packet generator or link: 64-bit data with sop/eop/en and eop byte-valid code.
// No ready signal; the source never stalls.
interface packet_check_if;
  logic [63:0] rx_data;
  logic        rx_data_en;
  logic        rx_data_sop;
  logic        rx_data_eop;
  logic [2:0]  rx_data_byte_vaild;

  modport master (
    output rx_data, rx_data_en, rx_data_sop, rx_data_eop, rx_data_byte_vaild
  );
  modport slave (
    input rx_data, rx_data_en, rx_data_sop, rx_data_eop, rx_data_byte_vaild
  );
endinterface

// File: rtl/packet_check.sv
// Checks each beat against the generator format, keeps saturating good/bad counters and sticky error state.
// Verdict pulses and counters land one cycle after the deciding beat; no backpressure, en=0 cycles just hold.
module packet_check #(
  parameter int          CNT_W    = 32,
  parameter logic [63:0] MARK_PAT = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter logic [63:0] TAIL_PAT = 64'hAAAA_AAAA_AAAA_AAAA,
  parameter int          LEN_MIN  = 100,
  parameter int          LEN_ADD  = 120,
  parameter int          LEN_MAX  = 253,
  parameter int          LEN_SUB  = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  packet_check_if.slave    rx,
  input  logic             clr_stats,
  output logic             pkt_done,
  output logic             pkt_ok,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag,
  output logic [3:0]       last_err_code,
  output logic [7:0]       last_len,
  output logic [2:0]       last_byte_vaild
);

  typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

  localparam logic [3:0] E_NONE       = 4'd0;
  localparam logic [3:0] E_SOP_IN_PKT = 4'd1;
  localparam logic [3:0] E_EN_NO_SOP  = 4'd2;
  localparam logic [3:0] E_HDR_BAD    = 4'd3;
  localparam logic [3:0] E_MARK_BAD   = 4'd4;
  localparam logic [3:0] E_FILL_BAD   = 4'd5;
  localparam logic [3:0] E_TAIL_BAD   = 4'd6;
  localparam logic [3:0] E_EARLY_EOP  = 4'd7;
  localparam logic [3:0] E_LONG       = 4'd8;
  localparam logic [3:0] E_SOP_EOP    = 4'd9;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t      state, nxt_state, start_nxt, body_nxt;
  logic [7:0]  idx, nxt_idx;
  logic [7:0]  hdr_len, hdr_last;
  logic [3:0]  start_code, body_code, err_old, err_new;
  logic        good;
  logic [1:0]  n_err;
  logic [CNT_W:0] err_sum;

  assign hdr_len = rx.rx_data[7:0];

  always_comb begin
    hdr_last = hdr_len;
    if (hdr_len < 8'(LEN_MIN))
      hdr_last = hdr_len + 8'(LEN_ADD);
    else if (hdr_len > 8'(LEN_MAX))
      hdr_last = hdr_len - 8'(LEN_SUB);
  end

  // Verdict for a sop beat, identical from every state.
  always_comb begin
    start_code = E_NONE;
    start_nxt  = BODY;
    if (rx.rx_data_eop) begin
      start_code = E_SOP_EOP;
      start_nxt  = IDLE;
    end else if (rx.rx_data[63:8] != '0) begin
      start_code = E_HDR_BAD;
      start_nxt  = DROP;
    end
  end

  // Verdict for a non-sop beat in BODY; last_len doubles as the live expected last index.
  always_comb begin
    body_code = E_NONE;
    if (idx == last_len) begin
      if (!rx.rx_data_eop)
        body_code = E_LONG;
      else if (rx.rx_data != TAIL_PAT)
        body_code = E_TAIL_BAD;
    end else if (idx == 8'd1 && rx.rx_data != MARK_PAT) begin
      body_code = E_MARK_BAD;
    end else if (idx != 8'd1 && rx.rx_data != '0) begin
      body_code = E_FILL_BAD;
    end else if (rx.rx_data_eop) begin
      body_code = E_EARLY_EOP;
    end
    body_nxt = BODY;
    if (idx == last_len || body_code != E_NONE)
      body_nxt = rx.rx_data_eop ? IDLE : DROP;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      idx   <= 8'd0;
    end else begin
      state <= nxt_state;
      idx   <= nxt_idx;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    if (rx.rx_data_en) begin
      if (rx.rx_data_sop) begin
        nxt_state = start_nxt;
        nxt_idx   = 8'd1;
      end else begin
        case (state)
          IDLE: nxt_state = rx.rx_data_eop ? IDLE : DROP;
          BODY: begin
            nxt_state = body_nxt;
            nxt_idx   = idx + 8'd1;
          end
          DROP: if (rx.rx_data_eop) nxt_state = IDLE;
          default: nxt_state = IDLE;
        endcase
      end
    end
  end

  // A sop inside BODY can close the old packet and fail the new one on the same beat.
  always_comb begin
    err_old = E_NONE;
    err_new = E_NONE;
    good    = 1'b0;
    if (rx.rx_data_en) begin
      if (rx.rx_data_sop) begin
        err_new = start_code;
        if (state == BODY) err_old = E_SOP_IN_PKT;
      end else if (state == IDLE) begin
        err_old = E_EN_NO_SOP;
      end else if (state == BODY) begin
        err_old = body_code;
        good    = (idx == last_len) && (body_code == E_NONE);
      end
    end
  end

  assign n_err   = {1'b0, err_old != E_NONE} + {1'b0, err_new != E_NONE};
  assign err_sum = {1'b0, err_cnt} + {{(CNT_W-1){1'b0}}, n_err};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pkt_done        <= 1'b0;
      pkt_ok          <= 1'b0;
      pkt_cnt         <= '0;
      err_cnt         <= '0;
      err_flag        <= 1'b0;
      last_err_code   <= 4'd0;
      last_len        <= 8'd0;
      last_byte_vaild <= 3'd0;
    end else begin
      pkt_done <= good || (n_err != 2'd0);
      pkt_ok   <= good;
      if (rx.rx_data_en && rx.rx_data_sop)
        last_len <= hdr_last;
      if (rx.rx_data_en && rx.rx_data_eop)
        last_byte_vaild <= rx.rx_data_byte_vaild;
      if (clr_stats) begin
        pkt_cnt       <= '0;
        err_cnt       <= '0;
        err_flag      <= 1'b0;
        last_err_code <= 4'd0;
      end else begin
        if (good && pkt_cnt != '1)
          pkt_cnt <= pkt_cnt + CNT_ONE;
        if (n_err != 2'd0) begin
          err_cnt       <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
          err_flag      <= 1'b1;
          last_err_code <= (err_new != E_NONE) ? err_new : err_old;
        end
      end
    end
  end

endmodule

// File: tb/tb_packet_check.sv
// Directed bench for packet_check: packet table plus hand sequences for gaps, saturation, clear and reset.
module tb_packet_check;
  localparam int CW = 4;
  localparam logic [63:0] MARK = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] TAIL = 64'hAAAA_AAAA_AAAA_AAAA;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          clr_stats;
  logic          pkt_done, pkt_ok, err_flag;
  logic [CW-1:0] pkt_cnt, err_cnt;
  logic [3:0]    last_err_code;
  logic [7:0]    last_len;
  logic [2:0]    last_byte_vaild;

  packet_check_if rx_if();

  packet_check #(.CNT_W(CW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx_if), .clr_stats(clr_stats),
    .pkt_done(pkt_done), .pkt_ok(pkt_ok), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt),
    .err_flag(err_flag), .last_err_code(last_err_code), .last_len(last_len),
    .last_byte_vaild(last_byte_vaild)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_total = 0;
  int ok_total = 0;

  always @(negedge sys_clk) begin
    if (pkt_done) done_total <= done_total + 1;
    if (pkt_ok)   ok_total   <= ok_total + 1;
  end

  typedef struct {
    logic [7:0] len;
    int         last_idx;
    int         stop_idx;
    int         eop_idx;
    int         bad_idx;
    int         gap_at;
    int         gap_len;
    logic [2:0] bv;
    int         exp_done;
    int         exp_ok;
    logic       exp_done_end;
    int         exp_pkt;
    int         exp_err;
    logic [3:0] exp_code;
    logic       exp_flag;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic [7:0] len, int e, int stop, int eop, int bad, int gat, int glen,
                              logic [2:0] bv, int dn, int ok, logic dend, int pk, int er,
                              logic [3:0] code, logic flag);
    vec_t v;
    v.len = len; v.last_idx = e; v.stop_idx = stop; v.eop_idx = eop; v.bad_idx = bad;
    v.gap_at = gat; v.gap_len = glen; v.bv = bv; v.exp_done = dn; v.exp_ok = ok;
    v.exp_done_end = dend; v.exp_pkt = pk; v.exp_err = er; v.exp_code = code; v.exp_flag = flag;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(logic [7:0] len, int i, int e, int bad);
    logic [63:0] d;
    if (i == 0)      d = {56'd0, len};
    else if (i == 1) d = MARK;
    else if (i == e) d = TAIL;
    else             d = 64'd0;
    if (i == bad) d = d ^ 64'h100;
    return d;
  endfunction

  task automatic beat(input logic [63:0] d, input logic sop, input logic eop,
                      input logic [2:0] bv, input logic clr);
    @(negedge sys_clk);
    rx_if.rx_data            = d;
    rx_if.rx_data_en         = 1'b1;
    rx_if.rx_data_sop        = sop;
    rx_if.rx_data_eop        = eop;
    rx_if.rx_data_byte_vaild = bv;
    clr_stats                = clr;
  endtask

  task automatic idle_cycle();
    @(negedge sys_clk);
    rx_if.rx_data            = 64'd0;
    rx_if.rx_data_en         = 1'b0;
    rx_if.rx_data_sop        = 1'b0;
    rx_if.rx_data_eop        = 1'b0;
    rx_if.rx_data_byte_vaild = 3'd0;
    clr_stats                = 1'b0;
  endtask

  // Ends one cycle after the last beat, #1 past the negedge so the monitor has counted.
  task automatic send_pkt(input logic [7:0] len, input int e, input int stop, input int eop_at,
                          input int bad, input int gap_at, input int gap_len,
                          input logic [2:0] bv, input logic clr_eop);
    for (int i = 0; i <= stop; i++) begin
      if (i == gap_at) repeat (gap_len) idle_cycle();
      beat(beat_data(len, i, e, bad), i == 0, i == eop_at, (i == eop_at) ? bv : ~bv,
           clr_eop && (i == eop_at));
    end
    idle_cycle();
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pkt_done"}, 64'(pkt_done), 0);
    chk({tag, "_pkt_ok"}, 64'(pkt_ok), 0);
    chk({tag, "_pkt_cnt"}, 64'(pkt_cnt), 0);
    chk({tag, "_err_cnt"}, 64'(err_cnt), 0);
    chk({tag, "_err_flag"}, 64'(err_flag), 0);
    chk({tag, "_code"}, 64'(last_err_code), 0);
    chk({tag, "_last_len"}, 64'(last_len), 0);
    chk({tag, "_last_bv"}, 64'(last_byte_vaild), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, o0;
    vecs[0]  = mk(8'd150, 150, 150, 150, -1, -1, 0, 3'd5, 1, 1, 1'b1, 1, 0, 4'd0, 1'b0);
    vecs[1]  = mk(8'd20,  140, 140, 140, -1, 60, 7, 3'd3, 1, 1, 1'b1, 2, 0, 4'd0, 1'b0);
    vecs[2]  = mk(8'd255, 252, 252, 252, -1, -1, 0, 3'd7, 1, 1, 1'b1, 3, 0, 4'd0, 1'b0);
    vecs[3]  = mk(8'd99,  219, 219, 219, -1, -1, 0, 3'd1, 1, 1, 1'b1, 4, 0, 4'd0, 1'b0);
    vecs[4]  = mk(8'd100, 100, 100, 100, -1, -1, 0, 3'd2, 1, 1, 1'b1, 5, 0, 4'd0, 1'b0);
    vecs[5]  = mk(8'd253, 253, 253, 253, -1, -1, 0, 3'd4, 1, 1, 1'b1, 6, 0, 4'd0, 1'b0);
    vecs[6]  = mk(8'd254, 251, 251, 251, -1, -1, 0, 3'd6, 1, 1, 1'b1, 7, 0, 4'd0, 1'b0);
    vecs[7]  = mk(8'd150, 150, 150, 150, 10, -1, 0, 3'd5, 1, 0, 1'b0, 7, 1, 4'd5, 1'b1);
    vecs[8]  = mk(8'd150, 150, 150, 150, -1, -1, 0, 3'd3, 1, 1, 1'b1, 8, 1, 4'd5, 1'b1);
    vecs[9]  = mk(8'd150, 150, 120, 120, -1, -1, 0, 3'd2, 1, 0, 1'b1, 8, 2, 4'd7, 1'b1);
    vecs[10] = mk(8'd150, 150, 150, 150,  0, -1, 0, 3'd1, 1, 0, 1'b0, 8, 3, 4'd3, 1'b1);
    vecs[11] = mk(8'd150, 150, 150, 150,  1, -1, 0, 3'd6, 1, 0, 1'b0, 8, 4, 4'd4, 1'b1);
    vecs[12] = mk(8'd150, 150, 150, 150, 150, -1, 0, 3'd7, 1, 0, 1'b1, 8, 5, 4'd6, 1'b1);
    vecs[13] = mk(8'd150, 150, 155, 155, -1, -1, 0, 3'd4, 1, 0, 1'b0, 8, 6, 4'd8, 1'b1);

    sys_rst_n = 1'b0;
    clr_stats = 1'b0;
    rx_if.rx_data = 64'd0; rx_if.rx_data_en = 1'b0; rx_if.rx_data_sop = 1'b0;
    rx_if.rx_data_eop = 1'b0; rx_if.rx_data_byte_vaild = 3'd0;
    repeat (3) @(negedge sys_clk);
    #1;
    chk_all_zero("reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      d0 = done_total;
      o0 = ok_total;
      send_pkt(vecs[i].len, vecs[i].last_idx, vecs[i].stop_idx, vecs[i].eop_idx, vecs[i].bad_idx,
               vecs[i].gap_at, vecs[i].gap_len, vecs[i].bv, 1'b0);
      chk($sformatf("v%0d_done_pulses", i), 64'(done_total - d0), 64'(vecs[i].exp_done));
      chk($sformatf("v%0d_ok_pulses", i), 64'(ok_total - o0), 64'(vecs[i].exp_ok));
      chk($sformatf("v%0d_done_end", i), 64'(pkt_done), 64'(vecs[i].exp_done_end));
      chk($sformatf("v%0d_pkt_cnt", i), 64'(pkt_cnt), 64'(vecs[i].exp_pkt));
      chk($sformatf("v%0d_err_cnt", i), 64'(err_cnt), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d_code", i), 64'(last_err_code), 64'(vecs[i].exp_code));
      chk($sformatf("v%0d_err_flag", i), 64'(err_flag), 64'(vecs[i].exp_flag));
      chk($sformatf("v%0d_last_len", i), 64'(last_len), 64'(vecs[i].last_idx));
      chk($sformatf("v%0d_last_bv", i), 64'(last_byte_vaild), 64'(vecs[i].bv));
    end

    // After the long packet's eop the checker must be back in IDLE: a bare en beat is code 2.
    beat(64'd0, 1'b0, 1'b0, 3'd0, 1'b0); idle_cycle(); #1;
    chk("no_sop_err_cnt", 64'(err_cnt), 7);
    chk("no_sop_code", 64'(last_err_code), 2);
    chk("no_sop_done", 64'(pkt_done), 1);
    beat(64'd0, 1'b0, 1'b1, 3'd5, 1'b0); idle_cycle(); #1;
    chk("drop_eop_err_cnt", 64'(err_cnt), 7);
    chk("drop_eop_done", 64'(pkt_done), 0);
    chk("drop_eop_bv", 64'(last_byte_vaild), 5);
    beat(64'd0, 1'b0, 1'b1, 3'd6, 1'b0); idle_cycle(); #1;
    chk("eop_no_sop_err_cnt", 64'(err_cnt), 8);
    chk("eop_no_sop_code", 64'(last_err_code), 2);
    beat({56'd0, 8'd150}, 1'b1, 1'b1, 3'd2, 1'b0); idle_cycle(); #1;
    chk("sop_eop_err_cnt", 64'(err_cnt), 9);
    chk("sop_eop_code", 64'(last_err_code), 9);
    chk("sop_eop_ok", 64'(pkt_ok), 0);

    // Second sop at idx 50 aborts the first packet; the restarted packet is good.
    d0 = done_total;
    o0 = ok_total;
    send_pkt(8'd150, 150, 49, -1, -1, -1, 0, 3'd0, 1'b0);
    send_pkt(8'd150, 150, 150, 150, -1, -1, 0, 3'd5, 1'b0);
    chk("resop_err_cnt", 64'(err_cnt), 10);
    chk("resop_code", 64'(last_err_code), 1);
    chk("resop_pkt_cnt", 64'(pkt_cnt), 9);
    chk("resop_done_pulses", 64'(done_total - d0), 2);
    chk("resop_ok_pulses", 64'(ok_total - o0), 1);

    // Clear coincident with a good completion: clear wins, pulse still fires.
    send_pkt(8'd20, 140, 140, 140, -1, -1, 0, 3'd6, 1'b1);
    chk("clr_ok", 64'(pkt_ok), 1);
    chk("clr_pkt_cnt", 64'(pkt_cnt), 0);
    chk("clr_err_cnt", 64'(err_cnt), 0);
    chk("clr_flag", 64'(err_flag), 0);
    chk("clr_code", 64'(last_err_code), 0);
    chk("clr_last_len", 64'(last_len), 140);

    // Saturation: 17 errors into a 4-bit counter.
    repeat (17) beat(64'd0, 1'b0, 1'b1, 3'd3, 1'b0);
    idle_cycle(); #1;
    chk("sat_err_cnt", 64'(err_cnt), 15);
    chk("sat_code", 64'(last_err_code), 2);
    chk("sat_pkt_cnt", 64'(pkt_cnt), 0);

    // Asynchronous reset in the middle of a packet.
    for (int i = 0; i < 30; i++)
      beat(beat_data(8'd150, i, 150, -1), i == 0, 1'b0, 3'd1, 1'b0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    idle_cycle();
    sys_rst_n = 1'b1;
    d0 = done_total;
    send_pkt(8'd150, 150, 150, 150, -1, -1, 0, 3'd5, 1'b0);
    chk("post_rst_pkt_cnt", 64'(pkt_cnt), 1);
    chk("post_rst_err_cnt", 64'(err_cnt), 0);
    chk("post_rst_done_pulses", 64'(done_total - d0), 1);

    @(negedge sys_clk);
    clr_stats = 1'b1;
    idle_cycle(); #1;
    chk("clr_only_pkt_cnt", 64'(pkt_cnt), 0);
    chk("clr_only_last_len", 64'(last_len), 150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
